// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: operand width,
// operation codes and FSM states.
package mdu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply step or restoring
// shift-subtract divide step on a (2*XLEN+1)-bit accumulator.
module mdu_step #(
  parameter int XLEN = mdu_pkg::XLEN
) (
  input  logic              mode,
  input  logic [2*XLEN:0]   acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN:0]   acc_next,
  output logic              q_bit
);

  logic [XLEN:0]   sum;
  logic [2*XLEN:0] sh;
  logic [XLEN+1:0] diff;

  // Multiply: acc = {partial product (XLEN+1), multiplier bits}; shifts right.
  // Divide:   acc = {0, remainder, quotient/dividend bits}; shifts left.
  // The quotient bit is left clear in acc_next; the caller inserts q_bit.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
    acc_next = '0;
    q_bit    = 1'b0;
    sum      = acc[2*XLEN:XLEN] + (acc[0] ? {1'b0, operand} : '0);
    sh       = {acc[2*XLEN-1:0], 1'b0};
    diff     = {1'b0, sh[2*XLEN:XLEN]} - {2'b00, operand};
    if (mode) begin
      q_bit    = ~diff[XLEN+1];
      acc_next = q_bit ? {diff[XLEN:0], sh[XLEN-1:0]} : sh;
    end else begin
      q_bit    = acc[0];
      acc_next = {1'b0, sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle MIPS-style multiply/divide unit with HI/LO registers, fed
// straight from the register-file read ports.
module mdu #(
  parameter int XLEN = mdu_pkg::XLEN,
  parameter int ITER = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done
);

  import mdu_pkg::*;

  localparam int CW = $clog2(ITER + 1);

  state_e          state;
  logic [CW-1:0]   cnt;
  op_e             op_r;
  logic            sa, sb, b_zero;
  logic [XLEN-1:0] a_raw, opnd;
  logic [2*XLEN:0] acc, step_acc;
  logic            q_bit;

  op_e             op_in;
  logic            sgn_a, sgn_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] res_hi, res_lo;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quot, rem;

  assign op_in = op_e'(op);
  assign sgn_a = op_is_signed(op_in) & a[XLEN-1];
  assign sgn_b = op_is_signed(op_in) & b[XLEN-1];
  assign mag_a = sgn_a ? -a : a;
  assign mag_b = sgn_b ? -b : b;

  mdu_step #(.XLEN(XLEN)) u_step (
    .mode     (op_is_div(op_r)),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (step_acc),
    .q_bit    (q_bit)
  );

  // Sign correction and the divide-by-zero override applied at FIN.
  always_comb begin
    prod   = acc[2*XLEN-1:0];
    quot   = acc[XLEN-1:0];
    rem    = acc[2*XLEN-1:XLEN];
    res_hi = '0;
    res_lo = '0;
    if (!op_is_div(op_r)) begin
      if (sa ^ sb) prod = -prod;
      res_hi = prod[2*XLEN-1:XLEN];
      res_lo = prod[XLEN-1:0];
    end else if (b_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end else begin
      res_lo = (sa ^ sb) ? -quot : quot;
      res_hi = sa ? -rem : rem;
    end
  end

  // Control and architectural state.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            cnt   <= CW'(ITER);
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= ST_FIN;
        end
        ST_FIN: begin
          hi    <= res_hi;
          lo    <= res_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; every operation reloads them before use.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      op_r   <= op_in;
      sa     <= sgn_a;
      sb     <= sgn_b;
      a_raw  <= a;
      b_zero <= (b == '0);
      acc    <= {{(XLEN+1){1'b0}}, op_is_div(op_in) ? mag_a : mag_b};
      opnd   <= op_is_div(op_in) ? mag_b : mag_a;
    end else if (state == ST_RUN) begin
      acc <= step_acc | {{(2*XLEN){1'b0}}, q_bit & op_is_div(op_r)};
    end
  end

endmodule
